// File: rtl/ifetch_queue.sv
// Instruction fetch front end: fetch-PC register, credit-limited imem requester,
// in-order prefetch FIFO with redirect/drain handling. Optional IFQ_BYPASS_EN.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        dbg_state
);
    // Handshakes: a transfer happens in a cycle where valid & ready are both high;
    // valid never depends on ready. imem responses carry no ready and arrive in order.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [AW-1:0] P_ONE = AW'(1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding, outstanding_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];
    logic [CW:0]   credit_used;
    logic          fire, rsp_dec, rsp_take, bypass, push, pop;

    assign imem_req_addr = fetch_pc;
    assign dbg_state     = state;

    always_comb begin
        credit_used    = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid = !rst && (state == FETCH) && !redirect_valid && (credit_used < CREDITS);
        fire           = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding belong to requests lost by reset.
        rsp_dec        = imem_rsp_valid && (outstanding != '0);
        rsp_take       = rsp_dec && (state == FETCH) && !redirect_valid;
`ifdef IFQ_BYPASS_EN
        bypass         = rsp_take && (count == '0);
`else
        bypass         = 1'b0;
`endif
        inst_valid     = !rst && !redirect_valid && ((count != '0) || bypass);
        pop            = inst_valid && inst_ready && (count != '0);
        push           = rsp_take && !(bypass && inst_ready);

        inst_data = '0;
        inst_pc   = '0;
        if (inst_valid) begin
            if (count != '0) begin
                inst_data = data_mem[rd_ptr];
                inst_pc   = pc_mem[rd_ptr];
            end else begin
                inst_data = imem_rsp_data;
                inst_pc   = tag_mem[tag_rd];
            end
        end

        outstanding_nxt = outstanding;
        if (fire && !rsp_dec)
            outstanding_nxt = outstanding + C_ONE;
        else if (!fire && rsp_dec)
            outstanding_nxt = outstanding - C_ONE;

        count_nxt = count;
        if (push && !pop)
            count_nxt = count + C_ONE;
        else if (!push && pop)
            count_nxt = count - C_ONE;

        // Leaving DRAIN (or skipping it) requires every stale response to be gone.
        state_nxt = state;
        if (redirect_valid || (state == DRAIN))
            state_nxt = (outstanding_nxt != '0) ? DRAIN : FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                count <= count_nxt;
                if (fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                    tag_wr   <= tag_wr + P_ONE;
                end
                if (rsp_take) tag_rd <= tag_rd + P_ONE;
                if (push)     wr_ptr <= wr_ptr + P_ONE;
                if (pop)      rd_ptr <= rd_ptr + P_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= tag_mem[tag_rd];
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: per-cycle vector table, directed corner sequences and a
// randomised run against a latency-configurable memory model with a scoreboard.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
    localparam int IV0 = 1;
`else
    localparam int IV0 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        dbg_state;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_inst_pc;
        logic [31:0] exp_inst_data;
    } vec_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0, n_errors = 0;
    int          cyc = 0, lat = 1, stale_n = 0;
    int          fire_cnt = 0, first_fire_cyc = 0, iv_seen = 0;
    logic [31:0] exp_pc = RESET_PC, first_fire_addr = '0, last_fire_addr = '0;
    logic        rand_req = 0, rand_inst = 0, req_ready_fix = 1, inst_ready_fix = 1, inj_rsp = 0;
    logic        s_inst_valid, s_state, s_req_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: entered and left at posedge+1, outputs sampled at the negedge.
    task automatic tick(input logic redir, input logic [31:0] rpc);
        logic [63:0] e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
            if (stale_n > 0) stale_n--;
        end else if (inj_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_0000;
        end
        imem_req_ready = rand_req  ? ($urandom_range(0, 3) != 0) : req_ready_fix;
        inst_ready     = rand_inst ? ($urandom_range(0, 3) != 0) : inst_ready_fix;
        #4;
        s_inst_valid = inst_valid;
        s_state      = dbg_state;
        s_req_valid  = imem_req_valid;
        if (inst_valid) iv_seen++;
        if (redir) begin
            check("redir_no_req", imem_req_valid, 0);
            check("redir_no_inst", inst_valid, 0);
            exp_q.delete();
            stale_n = mem_q.size();
            exp_pc  = rpc;
        end
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {inst_pc, inst_data}, 64'h0);
                n_errors += (inst_pc == 0 && inst_data == 0) ? 1 : 0;
            end else begin
                e = exp_q.pop_front();
                check("pop_pc_data", {inst_pc, inst_data}, e);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            check("credit", exp_q.size() < DEPTH, 1);
            check("no_fire_in_drain", stale_n, 0);
            if (fire_cnt == 0) begin
                first_fire_addr = imem_req_addr;
                first_fire_cyc  = cyc;
            end
            last_fire_addr = imem_req_addr;
            fire_cnt++;
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_q.push_back({imem_req_addr, mem_word(imem_req_addr)});
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 0; imem_req_ready = 0; imem_rsp_valid = 0; inst_ready = 0;
        mem_q.delete();
        exp_q.delete();
        stale_n = 0;
        inj_rsp = 0; rand_req = 0; rand_inst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = RESET_PC;
    endtask

    task automatic drain();
        int b;
        rand_req = 0; rand_inst = 0; req_ready_fix = 0; inst_ready_fix = 1;
        b = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && b < 60) begin
            tick(0, '0);
            b++;
        end
        check("drain_done", exp_q.size() + mem_q.size(), 0);
        tick(0, '0);
        check("drain_idle", s_inst_valid, 0);
    endtask

    initial begin
        vec_t vecs[8];
        logic [31:0] a;

        for (int k = 0; k < 8; k++) begin
            vecs[k].rsp_valid      = (k >= 1);
            a                      = 32'(4 * (k - 1));
            vecs[k].rsp_data       = (k >= 1) ? mem_word(a) : 32'h0;
            vecs[k].exp_req_valid  = 1'b1;
            vecs[k].exp_req_addr   = 32'(4 * k);
            vecs[k].exp_inst_valid = (k >= IV0);
            a                      = 32'(4 * (k - IV0));
            vecs[k].exp_inst_pc    = a;
            vecs[k].exp_inst_data  = mem_word(a);
        end

        #1 rst = 1'b1;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: 1-cycle memory, decode always ready.
        for (int k = 0; k < 8; k++) begin
            redirect_valid = 0;
            imem_req_ready = 1;
            inst_ready     = 1;
            imem_rsp_valid = vecs[k].rsp_valid;
            imem_rsp_data  = vecs[k].rsp_data;
            #4;
            check("tbl_req_valid", imem_req_valid, vecs[k].exp_req_valid);
            if (vecs[k].exp_req_valid) check("tbl_req_addr", imem_req_addr, vecs[k].exp_req_addr);
            check("tbl_inst_valid", inst_valid, vecs[k].exp_inst_valid);
            if (vecs[k].exp_inst_valid) begin
                check("tbl_inst_pc", inst_pc, vecs[k].exp_inst_pc);
                check("tbl_inst_data", inst_data, vecs[k].exp_inst_data);
            end
            @(posedge clk);
            #1;
        end

        // Backpressure fills exactly DEPTH credits, then releases in order.
        do_reset();
        lat = 1; req_ready_fix = 1; inst_ready_fix = 0; fire_cnt = 0;
        repeat (10) tick(0, '0);
        check("bp_fire_cnt", fire_cnt, DEPTH);
        check("bp_last_addr", last_fire_addr, 32'hC);
        check("bp_req_blocked", s_req_valid, 0);
        check("bp_inst_valid", s_inst_valid, 1);
        inst_ready_fix = 1; fire_cnt = 0;
        repeat (6) tick(0, '0);
        check("bp_resume_addr", first_fire_addr, 32'h10);
        drain();

        // Redirect with two requests in flight at latency 3.
        begin
            int rcyc;
            do_reset();
            lat = 3; req_ready_fix = 1; inst_ready_fix = 1;
            tick(0, '0);
            tick(0, '0);
            rcyc = cyc; fire_cnt = 0;
            tick(1, 32'h100);
            tick(0, '0);
            check("drain_inst_valid", s_inst_valid, 0);
            check("drain_state", s_state, 1);
            for (int i = 0; i < 10 && fire_cnt == 0; i++) tick(0, '0);
            check("drain_fire_cyc", first_fire_cyc, rcyc + 3);
            check("drain_fire_addr", first_fire_addr, 32'h100);
            drain();
        end

        // Redirect coinciding with the only outstanding response: no drain.
        begin
            int rcyc;
            do_reset();
            lat = 2; req_ready_fix = 1; inst_ready_fix = 1;
            tick(0, '0);
            req_ready_fix = 0;
            tick(0, '0);
            rcyc = cyc; fire_cnt = 0; req_ready_fix = 1;
            tick(1, 32'h200);
            tick(0, '0);
            check("nodrain_state", s_state, 0);
            check("nodrain_fire_cyc", first_fire_cyc, rcyc + 1);
            check("nodrain_fire_addr", first_fire_addr, 32'h200);
            drain();
        end

        // Fetch PC wraps at the top of the address space.
        do_reset();
        lat = 1; req_ready_fix = 0; inst_ready_fix = 1;
        tick(1, 32'hFFFF_FFFC);
        req_ready_fix = 1; fire_cnt = 0;
        tick(0, '0);
        tick(0, '0);
        check("wrap_first", first_fire_addr, 32'hFFFF_FFFC);
        check("wrap_next", last_fire_addr, 32'h0);
        drain();

        // Asynchronous reset mid-operation, then stale responses.
        do_reset();
        lat = 3; req_ready_fix = 1; inst_ready_fix = 0; fire_cnt = 0;
        repeat (5) tick(0, '0);
        check("mid_fires", fire_cnt, DEPTH);
        check("mid_fifo_busy", s_inst_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid", imem_req_valid, 0);
        check("mid_rst_inst_valid", inst_valid, 0);
        check("mid_rst_inst_data", inst_data, 0);
        check("mid_rst_inst_pc", inst_pc, 0);
        check("mid_rst_state", dbg_state, 0);
        mem_q.delete(); exp_q.delete(); stale_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = RESET_PC;
        req_ready_fix = 0; inst_ready_fix = 1; inj_rsp = 1; iv_seen = 0;
        repeat (3) tick(0, '0);
        inj_rsp = 0;
        tick(0, '0);
        check("stale_ignored", iv_seen, 0);
        lat = 1; req_ready_fix = 1; fire_cnt = 0;
        tick(0, '0);
        check("restart_addr", first_fire_addr, RESET_PC);
        drain();

        // Randomised traffic with occasional redirects.
        for (int l = 1; l <= 3; l += 2) begin
            lat = l; rand_req = 1; rand_inst = 1;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 24) == 0)
                    tick(1, $urandom() & 32'hFFFF_FFFC);
                else
                    tick(0, '0);
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
